// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: load/store funct3 codes,
// responder FSM encoding and access-size helpers.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Undefined funct3 codes fall through to word access.
  function automatic size_e f3_size(input logic [2:0] f3);
    size_e s;
    s = SZ_W;
    if (f3 == F3_B || f3 == F3_BU) s = SZ_B;
    if (f3 == F3_H || f3 == F3_HU) s = SZ_H;
    return s;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    size_e s;
    s = f3_size(f3);
    return (s == SZ_H && lo[0]) ||
           (s == SZ_W && lo != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage load/store port: request and response
// valid/ready channels between pipeline and memory.
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_f3,
    output req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_f3,
    input  req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores (merge + enables)
// and lane extraction/extension for loads.
module dmem_lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]  f3_i,
  input  logic [1:0]  lo_i,
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] wword_o,
  output logic [3:0]  be_o,
  output logic [31:0] rdata_o
);

  size_e       sz;
  logic [1:0]  lo_h;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  logic [31:0] wsrc;

  // Lane decode; low bits beyond natural alignment are dropped.
  always_comb begin
    sz      = f3_size(f3_i);
    lo_h    = {lo_i[1], 1'b0};
    bsel    = old_i[{lo_i, 3'b000} +: 8];
    hsel    = old_i[{lo_i[1], 4'b0000} +: 16];
    be_o    = 4'b1111;
    wsrc    = wdata_i;
    rdata_o = old_i;
    unique case (1'b1)
      (sz == SZ_B): begin
        be_o = 4'b0001 << lo_i;
        wsrc = {4{wdata_i[7:0]}};
        rdata_o = (f3_i == F3_B) ?
          {{24{bsel[7]}}, bsel} :
          {24'h0, bsel};
      end
      (sz == SZ_H): begin
        be_o = 4'b0011 << lo_h;
        wsrc = {2{wdata_i[15:0]}};
        rdata_o = (f3_i == F3_H) ?
          {{16{hsel[15]}}, hsel} :
          {16'h0, hsel};
      end
      default: begin
        be_o    = 4'b1111;
        wsrc    = wdata_i;
        rdata_o = old_i;
      end
    endcase
  end

  // Merged word: enabled lanes from store data, rest kept.
  always_comb begin
    wword_o = old_i;
    for (int i = 0; i < 4; i++) begin
      if (be_o[i]) wword_o[i*8 +: 8] = wsrc[i*8 +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with fixed access latency.
// Build option MISALIGN_TRAP_EN: fault misaligned accesses.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int CNT_W = 4;
  localparam int DEPTH = 2 ** ADDR_W;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [31:0]       old_w;
  logic [31:0]       wword;
  logic [3:0]        be;
  logic [31:0]       ld;
  logic              bad;
  logic              done;
  logic              commit;

  assign idx   = addr_q[ADDR_W+1:2];
  assign old_w = mem[idx];
  assign done  = (state_q == WAIT) && (cnt_q == '0);

`ifdef MISALIGN_TRAP_EN
  assign bad = misaligned(f3_q, addr_q[1:0]);
`else
  assign bad = 1'b0;
`endif

  assign commit = done && we_q && !bad;

  dmem_lane_align u_align (
    .f3_i    (f3_q),
    .lo_i    (addr_q[1:0]),
    .old_i   (old_w),
    .wdata_i (wdata_q),
    .wword_o (wword),
    .be_o    (be),
    .rdata_o (ld)
  );

  // Request latch, latency countdown and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= F3_W;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            state_q <= WAIT;
            cnt_q   <= CNT_W'(LATENCY - 1);
            we_q    <= bus.req_we;
            f3_q    <= bus.req_f3;
            addr_q  <= bus.req_addr[ADDR_W+1:0];
            wdata_q <= bus.req_wdata;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            rdata_q <= (we_q || bad) ? '0 : ld;
            err_q   <= bad;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Store commit on the WAIT->RESP edge, enabled lanes only.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (commit && be[i]) begin
        mem[idx][i*8 +: 8] <= wword[i*8 +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder
// against a byte-addressed reference memory.
module tb_dmem_responder;
  import riscv_pkg::*;

  localparam int ADDR_W = 10;
  localparam int LAT    = 2;
  localparam int MB     = 4 * (2 ** ADDR_W);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(
    .ADDR_W  (ADDR_W),
    .LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] ref_mem [MB];

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Little-endian byte memory; naturally aligned accesses.
  function automatic void ref_op(
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rd,
    output logic        er
  );
    int sz;
    int a;
    logic [31:0] v;
    sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 :
         (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    a  = int'(addr % MB);
    rd = 32'h0;
    er = 1'b0;
    if (a % sz != 0) begin
`ifdef MISALIGN_TRAP_EN
      er = 1'b1;
      return;
`else
      a = a - (a % sz);
`endif
    end
    if (we) begin
      for (int i = 0; i < sz; i++)
        ref_mem[a+i] = 8'(wdata >> (8 * i));
    end else begin
      v = 32'h0;
      for (int i = 0; i < sz; i++)
        v = v | (32'(ref_mem[a+i]) << (8 * i));
      if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end
  endfunction

  task automatic xact(
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  int          stall,
    output logic [31:0] rd,
    output logic        er
  );
    logic [31:0] exp_rd;
    logic        exp_er;
    int          n;
    ref_op(we, f3, addr, wdata, exp_rd, exp_er);
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_f3    = f3;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_we    = $urandom_range(0, 1);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    n = 1;
    while (!bus.rsp_valid && n < 50) begin
      if (bus.req_ready) chk("busy_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(LAT + 1));
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    chk("rdata", rd, exp_rd);
    chk("err", 32'(er), 32'(exp_er));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rdata", bus.rsp_rdata, exp_rd);
      chk("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] ra;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_f3    = F3_W;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_err", 32'(bus.rsp_err), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);

    xact(1, F3_W, 32'h10, 32'hDEAD_BEEF, 0, rd, er);
    xact(0, F3_W, 32'h10, 32'h0, 0, rd, er);
    chk("t1_lw", rd, 32'hDEAD_BEEF);
    xact(1, F3_B, 32'h11, 32'h80, 0, rd, er);
    xact(0, F3_W, 32'h10, 32'h0, 0, rd, er);
    chk("t2_word", rd, 32'hDEAD_80EF);
    xact(0, F3_B, 32'h11, 32'h0, 0, rd, er);
    chk("t2_lb", rd, 32'hFFFF_FF80);
    xact(0, F3_BU, 32'h11, 32'h0, 0, rd, er);
    chk("t2_lbu", rd, 32'h0000_0080);
    xact(1, F3_H, 32'h12, 32'h1234, 0, rd, er);
    xact(0, F3_H, 32'h12, 32'h0, 0, rd, er);
    chk("t3_lh", rd, 32'h0000_1234);
    xact(0, F3_HU, 32'h10, 32'h0, 5, rd, er);
    chk("t3_lhu", rd, 32'h0000_80EF);

    xact(0, F3_W, 32'h13, 32'h0, 0, rd, er);
`ifdef MISALIGN_TRAP_EN
    chk("t6_err", 32'(er), 32'd1);
    chk("t6_rdata", rd, 32'h0);
`else
    chk("t6_err", 32'(er), 32'd0);
    chk("t6_rdata", rd, 32'h1234_80EF);
`endif
    xact(0, F3_W, 32'h10 + 4 * (2 ** ADDR_W), 32'h0, 0, rd, er);
    chk("alias", rd, 32'h1234_80EF);

    xact(1, F3_W, 32'h20, 32'hA5A5_A5A5, 0, rd, er);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_f3    = F3_W;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h55;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("t5_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t5_rdata", bus.rsp_rdata, 32'd0);
    chk("t5_idle", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xact(0, F3_W, 32'h20, 32'h0, 0, rd, er);
    chk("t5_drop", rd, 32'hA5A5_A5A5);

    for (int w = 0; w < 16; w++)
      xact(1, F3_W, 32'(w * 4), $urandom, 0, rd, er);
    for (int t = 0; t < 80; t++) begin
      ra = ($urandom & 32'hFFFF_F000) |
           32'($urandom_range(0, 63));
      xact(1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)),
           ra, $urandom,
           $urandom_range(0, 2), rd, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
